// File: rtl/rot_pkg.sv
// Shared types for the rotate-command queue.
// One FIFO entry holds a complete rotate command.
package rot_pkg;

    localparam int ROT_W   = 16;
    localparam int SHIFT_W = 4;

    typedef struct packed {
        logic               lr;
        logic [SHIFT_W-1:0] shift;
        logic [ROT_W-1:0]   data;
    } rot_cmd_t;

endpackage

// File: rtl/rot_cmd_queue_if.sv
// Command-in / result-out handshake bundle for rot_cmd_queue.
// The master is the producer/consumer side, the slave is the queue.
interface rot_cmd_queue_if #(
    parameter int LVL_W = 3
);

    logic                              in_valid;
    logic                              in_ready;
    logic [rot_pkg::ROT_W-1:0]         in_data;
    logic [rot_pkg::SHIFT_W-1:0]       in_shift;
    logic                              in_lr;
    logic                              out_valid;
    logic                              out_ready;
    logic [rot_pkg::ROT_W-1:0]         out_data;
    logic [LVL_W-1:0]                  level;

    modport master (
        output in_valid, in_data, in_shift, in_lr, out_ready,
        input  in_ready, out_valid, out_data, level
    );

    modport slave (
        input  in_valid, in_data, in_shift, in_lr, out_ready,
        output in_ready, out_valid, out_data, level
    );

endinterface

// File: rtl/rotator.sv
// Combinational 16-bit barrel rotator.
// lr=1 rotates right, lr=0 rotates left, by shift positions.
module rotator (
    input  logic [3:0]  shift,
    input  logic        lr,
    input  logic [15:0] in,
    output logic [15:0] out
);

    // 4-bit index arithmetic wraps modulo 16, which is the rotation
    always_comb begin
        out = '0;
        for (int i = 0; i < 16; i++) begin
            if (lr) begin
                out[i] = in[4'(i) + shift];
            end else begin
                out[i] = in[4'(i) - shift];
            end
        end
    end

endmodule

// File: rtl/rot_cmd_queue.sv
// Buffered rotate-command front end: FIFO, rotator, registered output.
// Capacity is DEPTH queued commands plus one held result.
module rot_cmd_queue
    import rot_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LVL_W = 3
) (
    input logic       clk,
    input logic       reset,
    rot_cmd_queue_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);

    rot_cmd_t             mem [DEPTH];
    rot_cmd_t             head;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [LVL_W-1:0]     level;
    logic                 in_ready;
    logic                 out_valid;
    logic [ROT_W-1:0]     out_data;
    logic [ROT_W-1:0]     rot_out;
    logic                 push;
    logic                 load;

    assign in_ready = (level != LVL_W'(DEPTH));
    assign push     = bus.in_valid & in_ready;
    assign load     = (level != '0) & (~out_valid | bus.out_ready);
    assign head     = mem[rd_ptr];

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.level     = level;

    rotator u_rot (
        .shift (head.shift),
        .lr    (head.lr),
        .in    (head.data),
        .out   (rot_out)
    );

    // Storage needs no reset; only pointers and level define contents
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{
                lr:    bus.in_lr,
                shift: bus.in_shift,
                data:  bus.in_data
            };
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (load) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, load})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= rot_out;
        end else if (bus.out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
